button_debouncer: RTL and testbench
===================================

Name: button_debouncer

Overview:
- Input-side counterpart to the board's 7-segment output path: conditions raw push-button and GPIO-button inputs into clean, synchronous signals.
- Per button: 2-FF synchronizer, stability counter, debounced level, one-cycle press and release pulses.
- Feeds letter/digit selection and counter logic that drives the segment display.
- One instance per board covers all user buttons.

Parameters:
- N_BUTTONS, 3, number of independent button channels.
- STABLE_CYCLES, 50000, consecutive cycles a synchronized input must differ from the debounced level before it is accepted (1 ms at 50 MHz); legal range 2..2^20.
- REPEAT_DELAY, 25000000, cycles of continuous hold before the first auto-repeat pulse (used only with the optional feature).
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (used only with the optional feature).

Ports:
- clk, input, 1, single system clock.
- reset, input, 1, synchronous, active-high.
- btn_raw, input, N_BUTTONS, asynchronous raw button levels; 1 = pressed.
- btn_level, output, N_BUTTONS, debounced level, registered.
- btn_press, output, N_BUTTONS, one-cycle pulse on an accepted 0->1 transition (and auto-repeat, if enabled).
- btn_release, output, N_BUTTONS, one-cycle pulse on an accepted 1->0 transition.
- any_press, output, 1, registered OR of the next-state btn_press bits; asserted in the same cycle as btn_press.

Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.

Behaviour:
- Reset: sync FFs, btn_level, btn_press, btn_release, any_press and all counters go to 0. Reset dominates every other event, including mid-count; counting restarts from 0 after reset deasserts.
- Synchronizer: sync1 <= btn_raw; sync2 <= sync1. There is no other use of btn_raw.
- Stability counter, per channel, width $clog2(STABLE_CYCLES):
  - sync2 == btn_level: cnt <= 0.
  - sync2 != btn_level and cnt != STABLE_CYCLES-1: cnt <= cnt+1.
  - sync2 != btn_level and cnt == STABLE_CYCLES-1: btn_level <= sync2; cnt <= 0; pulse.
- Pulse: btn_press when the new level is 1, btn_release when it is 0, each high exactly one cycle.
- Latency: a raw level held stable and first sampled at edge E0 changes btn_level, and fires its pulse, at edge E0 + STABLE_CYCLES + 1.
- Glitch rejection: any bounce that returns sync2 to btn_level before acceptance clears cnt. A glitch shorter than STABLE_CYCLES cycles produces no output change.
- Channels are fully independent; simultaneous transitions on several buttons give simultaneous pulses.
- press and release are mutually exclusive per channel per cycle.
- No state machine beyond the counter; each channel is effectively IDLE (cnt = 0) / QUALIFYING (cnt > 0).

Optional Feature:
- Macro: BUTTON_DEBOUNCER_REPEAT_EN.
- Defined:
  - Each channel adds a repeat counter, cleared whenever btn_level is 0 or a press is accepted.
  - While btn_level stays 1, an extra btn_press pulse fires after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  - btn_release is unaffected.
- Undefined: no repeat logic is synthesized; REPEAT_* parameters are ignored; exactly one press pulse per accepted press.

Decomposition:
- Package button_debouncer_pkg holds:
  - default constants (STABLE_CYCLES_DEFAULT, REPEAT_DELAY_DEFAULT, REPEAT_PERIOD_DEFAULT);
  - a sim-friendly STABLE_CYCLES_SIM = 4;
  - a counter-width helper function.
- Sub-module debounce_channel: one button's sync, counter, level, pulses and optional repeat. The top generates N_BUTTONS instances and ORs the pulses into any_press.

Test Plan:
1. STABLE_CYCLES=4; reset 3 cycles; btn_raw=3'b001 set at E0 -> btn_level[0]=1 and btn_press[0]=1 at E0+5 for one cycle; any_press=1 in the same cycle; other bits stay 0.
2. STABLE_CYCLES=4; btn_raw[1] high for 3 cycles, then low -> btn_level, btn_press and btn_release stay 0 throughout.
3. Bounce 1,0,1,0,1 (1 cycle each), then held 1 -> accepted only 5 cycles after the final rising sample; exactly one btn_press.
4. Release after an accepted press -> btn_release pulse 5 cycles later, btn_level returns to 0, no btn_press.
5. reset asserted while cnt=2 -> next cycle all outputs 0, cnt=0; after deassert with input still 1, a full 5-cycle latency is required again.
6. With BUTTON_DEBOUNCER_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=3: hold btn_raw[2] -> press pulses at acceptance, +10, +13, +16. Without the macro -> a single pulse.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared constants and helpers for the button debouncer.
// Optional auto-repeat is enabled by defining BUTTON_DEBOUNCER_REPEAT_EN.
package button_debouncer_pkg;

   localparam int unsigned STABLE_CYCLES_DEFAULT = 32'd50000;
   localparam int unsigned REPEAT_DELAY_DEFAULT  = 32'd25000000;
   localparam int unsigned REPEAT_PERIOD_DEFAULT = 32'd5000000;
   localparam int unsigned STABLE_CYCLES_SIM     = 32'd4;

   // A counter that must reach n-1 needs clog2(n) bits, but never fewer than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = unsigned'($clog2(n));
      if (w < 32'd1) begin
         w = 32'd1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One button: 2-FF synchronizer, stability counter, debounced level and edge pulses.
// Auto-repeat on held presses is added when BUTTON_DEBOUNCER_REPEAT_EN is defined.
module debounce_channel
   import button_debouncer_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
   parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
`endif
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic press_next
);

   localparam int unsigned CW = cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 32'd1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          acc_press;
   logic          acc_release;

   always_comb begin
      sync1_d     = btn_raw;
      sync2_d     = sync1_q;
      cnt_d       = cnt_q;
      level_d     = level_q;
      acc_press   = 1'b0;
      acc_release = 1'b0;
      if (sync2_q == level_q) begin
         cnt_d = CNT_ZERO;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d       = CNT_ZERO;
         level_d     = sync2_q;
         acc_press   = sync2_q;
         acc_release = ~sync2_q;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
   localparam int unsigned REP_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned RW = cnt_width(REP_SPAN);
   localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY - 32'd1);
   localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD - 32'd1);
   localparam logic [RW-1:0] REP_ZERO   = RW'(32'd0);
   localparam logic [RW-1:0] REP_ONE    = RW'(32'd1);

   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   logic          rep_first_q, rep_first_d;
   logic          rep_pulse;

   // The first repeat waits REPEAT_DELAY; later ones use REPEAT_PERIOD. Any level change restarts it.
   always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
      rep_pulse   = 1'b0;
      if (!level_q || (level_d != level_q)) begin
         rep_cnt_d   = REP_ZERO;
         rep_first_d = 1'b0;
      end else if (!rep_first_q) begin
         if (rep_cnt_q == DELAY_MAX) begin
            rep_cnt_d   = REP_ZERO;
            rep_first_d = 1'b1;
            rep_pulse   = 1'b1;
         end else begin
            rep_cnt_d = rep_cnt_q + REP_ONE;
         end
      end else if (rep_cnt_q == PERIOD_MAX) begin
         rep_cnt_d = REP_ZERO;
         rep_pulse = 1'b1;
      end else begin
         rep_cnt_d = rep_cnt_q + REP_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rep_cnt_q   <= REP_ZERO;
         rep_first_q <= 1'b0;
      end else begin
         rep_cnt_q   <= rep_cnt_d;
         rep_first_q <= rep_first_d;
      end
   end

   assign press_d = acc_press | rep_pulse;
`else
   assign press_d = acc_press;
`endif

   assign release_d = acc_release;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         cnt_q     <= CNT_ZERO;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign press_next  = press_d;

endmodule

// File: rtl/button_debouncer.sv
// Debounces N_BUTTONS raw button inputs; any_press flags a press pulse on any channel.
// Optional auto-repeat is enabled by defining BUTTON_DEBOUNCER_REPEAT_EN.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int unsigned N_BUTTONS     = 32'd3,
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
   ,
   parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
   parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_BUTTONS-1:0] btn_raw,
   output logic [N_BUTTONS-1:0] btn_level,
   output logic [N_BUTTONS-1:0] btn_press,
   output logic [N_BUTTONS-1:0] btn_release,
   output logic                 any_press
);

   logic [N_BUTTONS-1:0] press_next;
   logic                 any_press_q, any_press_d;

   for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES)
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
         ,
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .btn_raw     (btn_raw[g]),
         .btn_level   (btn_level[g]),
         .btn_press   (btn_press[g]),
         .btn_release (btn_release[g]),
         .press_next  (press_next[g])
      );
   end

   // OR the next-state pulses so any_press lines up with btn_press.
   always_comb begin
      any_press_d = |press_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         any_press_q <= 1'b0;
      end else begin
         any_press_q <= any_press_d;
      end
   end

   assign any_press = any_press_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus randomized
// stimulus against a queue-based model of the acceptance rule.
module tb_button_debouncer;
   import button_debouncer_pkg::*;

   localparam int NB = 3;
   localparam int SC = int'(STABLE_CYCLES_SIM);
   localparam int RD = 10;
   localparam int RP = 3;
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
   localparam bit REP_ON = 1'b1;
`else
   localparam bit REP_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NB-1:0] btn_raw = '0;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic          any_press;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   button_debouncer #(
      .N_BUTTONS     (NB),
      .STABLE_CYCLES (SC)
`ifdef BUTTON_DEBOUNCER_REPEAT_EN
      ,
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP)
`endif
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .any_press   (any_press)
   );

   // Model: a level is accepted once the last SC synchronized samples all differ from it.
   bit m_s1 [NB];
   bit m_s2 [NB];
   bit m_lvl [NB];
   bit m_press [NB];
   bit m_rel [NB];
   int m_hold [NB];
   bit hist [NB][$];

   task automatic model_edge();
      for (int ch = 0; ch < NB; ch++) begin
         bit all_diff;
         m_press[ch] = 1'b0;
         m_rel[ch]   = 1'b0;
         if (reset) begin
            hist[ch].delete();
            m_s1[ch] = 1'b0; m_s2[ch] = 1'b0; m_lvl[ch] = 1'b0; m_hold[ch] = 0;
         end else begin
            hist[ch].push_back(m_s2[ch]);
            if (hist[ch].size() > SC) void'(hist[ch].pop_front());
            all_diff = (hist[ch].size() == SC);
            for (int k = 0; k < hist[ch].size(); k++)
               if (hist[ch][k] == m_lvl[ch]) all_diff = 1'b0;
            if (all_diff) begin
               m_lvl[ch] = m_s2[ch];
               hist[ch].delete();
               if (m_lvl[ch]) begin
                  m_press[ch] = 1'b1;
                  m_hold[ch]  = 0;
               end else begin
                  m_rel[ch] = 1'b1;
               end
            end else if (m_lvl[ch]) begin
               m_hold[ch]++;
               if (REP_ON && (m_hold[ch] == RD || (m_hold[ch] > RD && (m_hold[ch] - RD) % RP == 0)))
                  m_press[ch] = 1'b1;
            end
            m_s2[ch] = m_s1[ch];
            m_s1[ch] = btn_raw[ch];
         end
      end
   endtask

   function automatic logic [3*NB:0] exp_vec();
      logic [NB-1:0] l, p, r;
      for (int ch = 0; ch < NB; ch++) begin
         l[ch] = m_lvl[ch]; p[ch] = m_press[ch]; r[ch] = m_rel[ch];
      end
      return {l, p, r, |p};
   endfunction

   function automatic logic [3*NB:0] act_vec();
      return {btn_level, btn_press, btn_release, any_press};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      btn_raw = 3'b111;
      for (int t = 0; t < 3; t++) begin
         tick();
         n_cmp++;
         if (act_vec() !== {(3*NB+1){1'b0}} || act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset t=%0d: got %h expected %h", t, act_vec(), exp_vec());
         end
      end
      reset   = 1'b0;
      btn_raw = 3'b000;
      for (int t = 0; t < 3; t++) tick();
   endtask

   task automatic test_single_press();
      btn_raw = 3'b001;
      for (int t = 0; t < 8; t++) begin
         tick();
         n_cmp++;
         if (act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL single_press t=%0d: got %h expected %h", t, act_vec(), exp_vec());
         end
         if (t == 4 || t == 5) begin
            n_cmp++;
            if ((t == 4 && btn_level !== 3'b000) ||
                (t == 5 && {btn_level, btn_press, any_press} !== {3'b001, 3'b001, 1'b1})) begin
               n_bad++;
               $display("FAIL single_press_latency t=%0d: got lvl=%b press=%b any=%b required lvl=%b", t,
                        btn_level, btn_press, any_press, (t == 5) ? 3'b001 : 3'b000);
            end
         end
      end
   endtask

   task automatic test_glitch();
      for (int t = 0; t < 11; t++) begin
         btn_raw = (t < 3) ? 3'b011 : 3'b001;
         tick();
         n_cmp++;
         if (act_vec() !== exp_vec() || {btn_level[1], btn_press[1], btn_release[1]} !== 3'b000) begin
            n_bad++;
            $display("FAIL glitch t=%0d: got %h expected %h (ch1 must stay quiet)", t, act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_bounce();
      logic [4:0] pat;
      int presses;
      pat = 5'b10101;
      presses = 0;
      for (int t = 0; t < 15; t++) begin
         btn_raw = {1'b0, (t < 5) ? pat[t] : 1'b1, 1'b1};
         tick();
         if (btn_press[1]) presses++;
         n_cmp++;
         if (act_vec() !== exp_vec() || btn_level[1] !== (t >= 9)) begin
            n_bad++;
            $display("FAIL bounce t=%0d: got %h expected %h lvl1=%b", t, act_vec(), exp_vec(), btn_level[1]);
         end
      end
      n_cmp++;
      if (presses != 1) begin
         n_bad++;
         $display("FAIL bounce_count: got %0d presses required 1", presses);
      end
   endtask

   task automatic test_release();
      btn_raw = 3'b000;
      for (int t = 0; t < 8; t++) begin
         tick();
         n_cmp++;
         if (act_vec() !== exp_vec() ||
             (t == 5 && {btn_level, btn_press, btn_release} !== {3'b000, 3'b000, 3'b011})) begin
            n_bad++;
            $display("FAIL release t=%0d: got %h expected %h", t, act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      btn_raw = 3'b100;
      for (int t = 0; t < 4; t++) tick();
      reset = 1'b1;
      tick();
      n_cmp++;
      if (act_vec() !== {(3*NB+1){1'b0}} || act_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL reset_mid: got %h expected 0", act_vec());
      end
      reset = 1'b0;
      for (int t = 0; t < 8; t++) begin
         tick();
         n_cmp++;
         if (act_vec() !== exp_vec() || btn_level[2] !== (t >= 5) || btn_press[2] !== (t == 5)) begin
            n_bad++;
            $display("FAIL reset_mid_relatch t=%0d: got %h expected %h", t, act_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_repeat();
      int got_q[$];
      int exp_q[$];
      if (REP_ON) exp_q = '{5, 15, 18, 21};
      else        exp_q = '{5};
      btn_raw = 3'b000;
      reset   = 1'b1;
      tick();
      reset   = 1'b0;
      btn_raw = 3'b100;
      for (int t = 0; t < 23; t++) begin
         tick();
         if (btn_press[2]) got_q.push_back(t);
         n_cmp++;
         if (act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL repeat t=%0d: got %h expected %h", t, act_vec(), exp_vec());
         end
      end
      n_cmp++;
      if (got_q != exp_q) begin
         n_bad++;
         $display("FAIL repeat_times: got %p required %p", got_q, exp_q);
      end
   endtask

   task automatic test_random();
      int slow;
      for (int t = 0; t < 1200; t++) begin
         slow = ((t / 150) % 2 == 0) ? 3 : 40;
         for (int ch = 0; ch < NB; ch++)
            if ($urandom_range(slow - 1, 0) == 0) btn_raw[ch] = ~btn_raw[ch];
         reset = ($urandom_range(299, 0) == 0);
         tick();
         n_cmp++;
         if (act_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL random t=%0d: got %h expected %h", t, act_vec(), exp_vec());
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_press();
      test_glitch();
      test_bounce();
      test_release();
      test_reset_mid();
      test_repeat();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
